// File: rtl/pwm2pcm_capture_if.sv
// Sample output channel of pwm2pcm_capture.
// Handshake: the producer (master) drives valid_o together with pcm_o and
// timeout_o; these stay stable while valid_o=1 and ready_i=0. A sample is
// consumed on a rising clk_i edge where valid_o=1 and ready_i=1.
// overrun_o is a sticky status flag, not part of the handshake.
interface pwm2pcm_capture_if;
  logic [7:0] pcm_o;
  logic       valid_o;
  logic       ready_i;
  logic       timeout_o;
  logic       overrun_o;

  modport master (output pcm_o, valid_o, timeout_o, overrun_o, input ready_i);
  modport slave  (input pcm_o, valid_o, timeout_o, overrun_o, output ready_i);
endinterface

// File: rtl/pwm2pcm_capture.sv
// pwm2pcm_capture: measures the high time of each period of an asynchronous
// PWM line and presents min(high_cycles, 255) as an 8-bit sample through a
// one-entry valid/ready buffer. A line that stays static for TIMEOUT_CYCLES
// produces saturated samples (0 when low, 255 when high) flagged by timeout_o.
// Optional build macro PWM2PCM_GLITCH_FILTER_EN: a 3-sample majority filter
// sits between the synchronizer and edge detection (adds two cycles).
module pwm2pcm_capture #(
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              pwm_i,
  pwm2pcm_capture_if.master smp,
  output logic [1:0]        dbg_state_o
);
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic sync1_q, sync2_q;
  logic line, line_d_q;
  logic rise_q, fall_q;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM2PCM_GLITCH_FILTER_EN
  // Edges become trustworthy once every stage up to line_d_q holds a real sample.
  localparam int PRIME_LEN = 6;
  logic [1:0] hist_q;
  logic       filt_q;

  // Majority of the three most recent synchronized samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end
  assign line = filt_q;
`else
  localparam int PRIME_LEN = 3;
  assign line = sync2_q;
`endif

  // After reset the pipeline holds zeros rather than real samples; a line that
  // is already high must not look like a rising edge, so edges are gated until
  // the pipeline has filled.
  logic [PRIME_LEN-1:0] prime_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) prime_q <= '0;
    else       prime_q <= {prime_q[PRIME_LEN-2:0], 1'b1};
  end

  // Registered edge detection against the one-cycle-delayed line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_d_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      line_d_q <= line;
      rise_q   <= line & ~line_d_q & prime_q[PRIME_LEN-1];
      fall_q   <= ~line & line_d_q & prime_q[PRIME_LEN-1];
    end
  end

  state_e      state_q, state_d;
  logic [8:0]  high_q, high_d;
  logic [15:0] period_q, period_d;
  logic        emit_d, emit_q;
  logic [7:0]  emit_pcm_d, emit_pcm_q;
  logic        emit_to_d, emit_to_q;
  logic [8:0]  high_inc;

  assign high_inc    = (high_q == 9'd511) ? 9'd511 : high_q + 9'd1;
  assign dbg_state_o = state_q;

  // Measurement FSM: state, counters and the sample to emit this cycle.
  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    period_d   = period_q;
    emit_d     = 1'b0;
    emit_pcm_d = 8'd0;
    emit_to_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        high_d   = 9'd0;
        period_d = 16'd0;
        state_d  = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        high_d   = 9'd0;
        period_d = 16'd0;
        if (rise_q) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall_q) begin
          state_d  = ST_LOW;
          high_d   = high_inc;
          period_d = period_q + 16'd1;
        end else if (period_q >= TIMEOUT_LAST) begin
          emit_d     = 1'b1;
          emit_pcm_d = 8'hFF;
          emit_to_d  = 1'b1;
          high_d     = 9'd0;
          period_d   = 16'd0;
        end else begin
          high_d   = high_inc;
          period_d = period_q + 16'd1;
        end
      end
      ST_LOW: begin
        if (rise_q) begin
          emit_d     = 1'b1;
          emit_pcm_d = (high_q > 9'd255) ? 8'hFF : high_q[7:0];
          high_d     = 9'd0;
          period_d   = 16'd0;
          state_d    = ST_HIGH;
        end else if (period_q >= TIMEOUT_LAST) begin
          emit_d     = 1'b1;
          emit_pcm_d = 8'h00;
          emit_to_d  = 1'b1;
          high_d     = 9'd0;
          period_d   = 16'd0;
        end else begin
          period_d = period_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable_i) begin
      state_d  = ST_IDLE;
      high_d   = 9'd0;
      period_d = 16'd0;
      emit_d   = 1'b0;
    end
  end

  // FSM state, counters and the one-cycle emit stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      high_q     <= 9'd0;
      period_q   <= 16'd0;
      emit_q     <= 1'b0;
      emit_pcm_q <= 8'd0;
      emit_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_q     <= high_d;
      period_q   <= period_d;
      emit_q     <= emit_d;
      emit_pcm_q <= emit_pcm_d;
      emit_to_q  <= emit_to_d;
    end
  end

  logic [7:0] pcm_q;
  logic       valid_q, timeout_q, overrun_q;

  // One-entry output buffer: a new sample always wins, overwriting an
  // unconsumed one sets the sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcm_q     <= 8'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!enable_i) begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (emit_q) begin
      pcm_q     <= emit_pcm_q;
      timeout_q <= emit_to_q;
      valid_q   <= 1'b1;
      if (valid_q && !smp.ready_i) overrun_q <= 1'b1;
    end else if (valid_q && smp.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign smp.pcm_o     = pcm_q;
  assign smp.valid_o   = valid_q;
  assign smp.timeout_o = timeout_q;
  assign smp.overrun_o = overrun_q;
endmodule

// File: tb/tb_pwm2pcm_capture.sv
// Bench for pwm2pcm_capture (default build, no glitch filter).
// The reference model works on the PWM line as driven: every rising edge after
// the first one yields min(high cycles since the previous anchor, 255), a line
// without a rising edge for TO cycles yields a saturated timeout sample, and
// each sample reaches the output LAT edges after the edge that sampled it.
module tb_pwm2pcm_capture;
  localparam int TO  = 512;
  localparam int LAT = 4;

  logic       clk_i = 1'b0;
  logic       rst_i, enable_i, pwm_i;
  logic [1:0] dbg_state;

  pwm2pcm_capture_if smp_if();

  pwm2pcm_capture #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .pwm_i       (pwm_i),
    .smp         (smp_if),
    .dbg_state_o (dbg_state)
  );

  // Clock: 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Line model: pending samples as (due cycle, {timeout, pcm}).
  int         exp_due[$];
  logic [8:0] exp_q[$];
  logic       m_prev = 1'b0, m_meas = 1'b0, m_wait = 1'b0;
  int         m_anchor = 0, m_ones = 0;
  // Buffer model.
  logic       m_hold = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
  logic [7:0] m_pcm = 8'd0;
  logic [10:0] obs, req;

  // Drive one line value, advance one edge, update the model.
  task automatic step(input logic v);
    logic rise, fall, due;
    logic [8:0] e;
    pwm_i = v;
    @(posedge clk_i);
    cyc++;
    due = (exp_due.size() > 0) && (exp_due[0] == cyc);
    if (rst_i || !enable_i) begin
      exp_due.delete();
      exp_q.delete();
      m_meas = 1'b0; m_wait = 1'b0; m_prev = v;
      m_hold = 1'b0; m_ovr = 1'b0;
      if (rst_i) m_pcm = 8'd0;
    end else begin
      if (due) begin
        e = exp_q.pop_front();
        void'(exp_due.pop_front());
        if (m_hold && !smp_if.ready_i) m_ovr = 1'b1;
        m_hold = 1'b1;
        {m_to, m_pcm} = e;
      end else if (m_hold && smp_if.ready_i) begin
        m_hold = 1'b0;
      end
      rise = v && !m_prev;
      fall = !v && m_prev;
      if (m_meas) begin
        if (rise) begin
          exp_due.push_back(cyc + LAT);
          exp_q.push_back({1'b0, (m_ones > 255) ? 8'hFF : 8'(m_ones)});
          m_anchor = cyc; m_ones = 0;
        end else if ((cyc - m_anchor >= TO) && !fall) begin
          exp_due.push_back(cyc + LAT);
          exp_q.push_back({1'b1, v ? 8'hFF : 8'h00});
          m_anchor = cyc; m_ones = 0;
        end
      end else if (m_wait && rise) begin
        m_meas = 1'b1; m_anchor = cyc; m_ones = 0;
      end
      m_wait = 1'b1;
      if (v) m_ones++;
      m_prev = v;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1; smp_if.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    checks++;
    if ({smp_if.valid_o, smp_if.pcm_o, smp_if.timeout_o, smp_if.overrun_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b pcm=%0d to=%b ovr=%b, required all 0",
               smp_if.valid_o, smp_if.pcm_o, smp_if.timeout_o, smp_if.overrun_o);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      obs = {smp_if.valid_o, smp_if.overrun_o, smp_if.pcm_o, smp_if.timeout_o & smp_if.valid_o};
      req = {m_hold, m_ovr, m_pcm, m_to & m_hold};
      checks++;
      if (obs !== req) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: got %h required %h", cyc, obs, req);
      end
    end
    checks++;
    if (dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL wait_state: got %0d required 1", dbg_state);
    end
  endtask

  // Fixed 64/256 waveform with ready=1, then random periods/duties/ready.
  task automatic test_duty();
    int p, h, n64;
    n64 = 0;
    for (int k = 0; k < 4; k++) begin
      p = (k == 0) ? 256 : $urandom_range(64, 300);
      h = (k == 0) ? 64 : $urandom_range(1, p - 1);
      for (int i = 0; i < 4 * p; i++) begin
        smp_if.ready_i = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        step((i % p) < h);
        obs = {smp_if.valid_o, smp_if.overrun_o, smp_if.pcm_o, smp_if.timeout_o & smp_if.valid_o};
        req = {m_hold, m_ovr, m_pcm, m_to & m_hold};
        checks++;
        if (obs !== req) begin
          errors++;
          if (errors < 20) $display("FAIL duty cyc=%0d p=%0d h=%0d: got %h required %h", cyc, p, h, obs, req);
        end
        if (k == 0 && smp_if.valid_o === 1'b1 && smp_if.pcm_o === 8'd64 && smp_if.timeout_o === 1'b0) n64++;
      end
    end
    // Rises at 0, 256, 512, 768: the first anchors, the next three give 64.
    checks++;
    if (n64 != 3) begin
      errors++;
      $display("FAIL duty64_count: got %0d samples of 64, required 3", n64);
    end
  endtask

  task automatic test_timeout();
    int n_lo, n_hi;
    logic v;
    n_lo = 0; n_hi = 0;
    smp_if.ready_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(1'b0);
      obs = {smp_if.valid_o, smp_if.overrun_o, smp_if.pcm_o, smp_if.timeout_o & smp_if.valid_o};
      req = {m_hold, m_ovr, m_pcm, m_to & m_hold};
      checks++;
      if (obs !== req) begin
        errors++;
        if (errors < 20) $display("FAIL timeout_pre cyc=%0d: got %h required %h", cyc, obs, req);
      end
    end
    // One 100/256 period, a high phase, then 1100 low; then one long high phase.
    for (int i = 0; i < 256 + 100 + 1100 + 1100; i++) begin
      if (i < 256)             v = (i < 100);
      else if (i < 356)        v = 1'b1;
      else if (i < 1456)       v = 1'b0;
      else                     v = 1'b1;
      step(v);
      obs = {smp_if.valid_o, smp_if.overrun_o, smp_if.pcm_o, smp_if.timeout_o & smp_if.valid_o};
      req = {m_hold, m_ovr, m_pcm, m_to & m_hold};
      checks++;
      if (obs !== req) begin
        errors++;
        if (errors < 20) $display("FAIL timeout cyc=%0d: got %h required %h", cyc, obs, req);
      end
      if (smp_if.valid_o === 1'b1 && smp_if.timeout_o === 1'b1 && smp_if.pcm_o === 8'd0)   n_lo++;
      if (smp_if.valid_o === 1'b1 && smp_if.timeout_o === 1'b1 && smp_if.pcm_o === 8'd255) n_hi++;
    end
    checks++;
    if (n_lo != 2) begin
      errors++;
      $display("FAIL timeout_low_count: got %0d required 2", n_lo);
    end
    checks++;
    if (n_hi != 2) begin
      errors++;
      $display("FAIL timeout_high_count: got %0d required 2", n_hi);
    end
  endtask

  task automatic test_overrun();
    rst_i = 1'b1; smp_if.ready_i = 1'b0;
    step(1'b0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 2 * 256 + 20; i++) begin
      step((i % 256) < 200);
      obs = {smp_if.valid_o, smp_if.overrun_o, smp_if.pcm_o, smp_if.timeout_o & smp_if.valid_o};
      req = {m_hold, m_ovr, m_pcm, m_to & m_hold};
      checks++;
      if (obs !== req) begin
        errors++;
        if (errors < 20) $display("FAIL overrun_stream cyc=%0d: got %h required %h", cyc, obs, req);
      end
    end
    checks++;
    if ({smp_if.valid_o, smp_if.pcm_o, smp_if.overrun_o} !== {1'b1, 8'd200, 1'b1}) begin
      errors++;
      $display("FAIL overrun_held: got valid=%b pcm=%0d ovr=%b, required valid=1 pcm=200 ovr=1",
               smp_if.valid_o, smp_if.pcm_o, smp_if.overrun_o);
    end
    smp_if.ready_i = 1'b1;
    step(1'b1);
    checks++;
    if ({smp_if.valid_o, smp_if.overrun_o} !== 2'b01) begin
      errors++;
      $display("FAIL overrun_consume: got valid=%b ovr=%b, required valid=0 ovr=1",
               smp_if.valid_o, smp_if.overrun_o);
    end
    for (int i = 0; i < 4; i++) step(1'b1);
    checks++;
    if (smp_if.overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b required 1", smp_if.overrun_o);
    end
  endtask

  task automatic test_disable();
    enable_i = 1'b0;
    step(1'b1);
    checks++;
    if ({smp_if.valid_o, smp_if.timeout_o, smp_if.overrun_o, smp_if.pcm_o} !== {3'b000, 8'd200}) begin
      errors++;
      $display("FAIL disable_clear: got valid=%b to=%b ovr=%b pcm=%0d, required 0 0 0 200",
               smp_if.valid_o, smp_if.timeout_o, smp_if.overrun_o, smp_if.pcm_o);
    end
    step(1'b1);
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL disable_state: got %0d required 0", dbg_state);
    end
    enable_i = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1);
  endtask

  task automatic test_glitch();
    int n_one;
    n_one = 0;
    smp_if.ready_i = 1'b1;
    for (int i = 0; i < 20 + 3 * 256; i++) begin
      if (i < 20) step(1'b0);
      else        step((((i - 20) % 256) < 100) || (i - 20 == 256 + 180));
      obs = {smp_if.valid_o, smp_if.overrun_o, smp_if.pcm_o, smp_if.timeout_o & smp_if.valid_o};
      req = {m_hold, m_ovr, m_pcm, m_to & m_hold};
      checks++;
      if (obs !== req) begin
        errors++;
        if (errors < 20) $display("FAIL glitch cyc=%0d: got %h required %h", cyc, obs, req);
      end
      if (smp_if.valid_o === 1'b1 && smp_if.timeout_o === 1'b0 && smp_if.pcm_o === 8'd1) n_one++;
    end
    checks++;
    if (n_one != 1) begin
      errors++;
      $display("FAIL glitch_sample_of_1: got %0d required 1", n_one);
    end
  endtask

  task automatic test_reset_mid();
    int rise_cyc, first_cyc;
    logic [7:0] first_pcm;
    rise_cyc = -1; first_cyc = -1; first_pcm = 8'd0;
    smp_if.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0);
    for (int i = 0; i < 4 * 256; i++) begin
      rst_i = (i == 256 + 40);
      step((i % 256) < 128);
      if (i == 256 + 40) begin
        checks++;
        if ({smp_if.valid_o, smp_if.pcm_o, smp_if.timeout_o, smp_if.overrun_o} !== 11'd0) begin
          errors++;
          $display("FAIL reset_mid_outputs: got valid=%b pcm=%0d to=%b ovr=%b, required all 0",
                   smp_if.valid_o, smp_if.pcm_o, smp_if.timeout_o, smp_if.overrun_o);
        end
      end
      if (i == 3 * 256) rise_cyc = cyc;
      if (i > 256 + 40 && first_cyc < 0 && smp_if.valid_o === 1'b1) begin
        first_cyc = cyc;
        first_pcm = smp_if.pcm_o;
      end
    end
    rst_i = 1'b0;
    checks++;
    if (first_pcm !== 8'd128) begin
      errors++;
      $display("FAIL reset_mid_first_pcm: got %0d required 128", first_pcm);
    end
    checks++;
    if (first_cyc != rise_cyc + LAT) begin
      errors++;
      $display("FAIL reset_mid_latency: got cycle %0d required %0d", first_cyc, rise_cyc + LAT);
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; pwm_i = 1'b0; smp_if.ready_i = 1'b1;
    test_reset();
    test_duty();
    test_timeout();
    test_overrun();
    test_disable();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
